// File: rtl/list_sum_sink_if.sv
// ============================================================================
//  Module      : list_sum_sink_if
//  Description : dfd list-stream handshake bundle (req/ack/eol/value).
//                The producer (list source) is the master: it drives
//                ack/eol/value and observes req. The consumer (list sink)
//                is the slave: it drives req and observes ack/eol/value.
//  Ports       : none (signal bundle only)
//                req    - element request, consumer -> producer
//                ack    - one-cycle producer strobe; eol/value valid with it
//                eol    - end of list; value ignored when set
//                value  - list element, N bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface list_sum_sink_if #(
    parameter int N = 8
) ();
    logic         req;
    logic         ack;
    logic         eol;
    logic [N-1:0] value;

    modport master (input req, output ack, output eol, output value);
    modport slave  (output req, input ack, input eol, input value);
endinterface

`default_nettype wire

// File: rtl/list_sum_sink.sv
// ============================================================================
//  Module      : list_sum_sink
//  Description : Downstream consumer of a dfd list stream. On a ready/done
//                call it requests list elements one at a time and sums them
//                until end-of-list, then presents result/count/overflow with
//                done held until the caller drops ready.
//  Ports       : clock       - system clock, rising edge
//                reset_n     - asynchronous active-low reset
//                ready       - call request (level, held for whole call)
//                done        - result valid, held until ready falls
//                result      - sum of consumed elements mod 2^ACC_W
//                count       - number of elements consumed (saturating)
//                overflow    - sticky carry-out of the accumulator
//                timeout_err - only with LIST_SUM_TIMEOUT_EN: REQ timed out
//                lst         - list handshake (slave side)
//  Options     : LIST_SUM_TIMEOUT_EN - adds TIMEOUT parameter, timeout_err
//                port and a no-ack watchdog in the request state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module list_sum_sink #(
    parameter int N     = 8,
    parameter int ACC_W = 16,   // must be >= N
    parameter int CNT_W = 8
`ifdef LIST_SUM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             ready,
    output logic                  done,
    output logic [ACC_W-1:0]      result,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
`ifdef LIST_SUM_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    list_sum_sink_if.slave        lst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [N-1:0]       value_w;
    logic [ACC_W:0]     sum_w;      // extra MSB is the carry-out

    assign value_w = lst.value;
    assign sum_w   = {1'b0, result_q} + (ACC_W + 1)'(value_w);

`ifdef LIST_SUM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               terr_q, terr_d;
`endif

    // Outputs are pure decodes of state so that an asynchronous reset drops
    // req/done immediately without waiting for a clock edge.
    assign lst.req  = (state_q == S_REQ);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign count    = count_q;
    assign overflow = overflow_q;
`ifdef LIST_SUM_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef LIST_SUM_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef LIST_SUM_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef LIST_SUM_TIMEOUT_EN
        // Cleared by default: only an ack-less REQ cycle advances it.
        tmo_cnt_d  = '0;
        terr_d     = terr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    result_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
`ifdef LIST_SUM_TIMEOUT_EN
                    terr_d     = 1'b0;
`endif
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // Abort has priority over a same-cycle ack.
                if (!ready) begin
                    state_d = S_IDLE;
                end else if (lst.ack) begin
                    if (lst.eol) begin
                        state_d = S_DONE;
                    end else begin
                        result_d   = sum_w[ACC_W-1:0];
                        overflow_d = overflow_q | sum_w[ACC_W];
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        state_d = S_GAP;
                    end
                end
`ifdef LIST_SUM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            S_GAP: begin
                // One req-low cycle between elements.
                state_d = ready ? S_REQ : S_IDLE;
            end
            S_DONE: begin
                if (!ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_list_sum_sink.sv
// ============================================================================
//  Module      : tb_list_sum_sink
//  Description : Directed self-checking bench for list_sum_sink. Two DUTs
//                see identical stimulus: one with ACC_W=16 and one with
//                ACC_W=8, so wrap/overflow behaviour can be compared against
//                the non-wrapping sum for the same list.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_list_sum_sink;

    logic clock;
    logic reset_n;
    logic ready;

    logic        done_a, done_b;
    logic [15:0] result_a;
    logic [7:0]  result_b;
    logic [7:0]  count_a, count_b;
    logic        ovf_a, ovf_b;
`ifdef LIST_SUM_TIMEOUT_EN
    logic        terr_a, terr_b;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    list_sum_sink_if #(.N(8)) ifa ();
    list_sum_sink_if #(.N(8)) ifb ();

    assign ifb.ack   = ifa.ack;
    assign ifb.eol   = ifa.eol;
    assign ifb.value = ifa.value;

    list_sum_sink #(
        .N(8), .ACC_W(16), .CNT_W(8)
`ifdef LIST_SUM_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) u_dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .ready       (ready),
        .done        (done_a),
        .result      (result_a),
        .count       (count_a),
        .overflow    (ovf_a),
`ifdef LIST_SUM_TIMEOUT_EN
        .timeout_err (terr_a),
`endif
        .lst         (ifa.slave)
    );

    list_sum_sink #(
        .N(8), .ACC_W(8), .CNT_W(8)
`ifdef LIST_SUM_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) u_dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .ready       (ready),
        .done        (done_b),
        .result      (result_b),
        .count       (count_b),
        .overflow    (ovf_b),
`ifdef LIST_SUM_TIMEOUT_EN
        .timeout_err (terr_b),
`endif
        .lst         (ifb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for req, let it stay high for dly more cycles, then
    // strobe ack for one cycle. Returns at the negedge after the ack edge.
    task automatic send(input logic e, input logic [7:0] v, input int dly);
        int t = 0;
        while (!ifa.req && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("req_wait", {31'd0, ifa.req}, 32'd1);
        repeat (dly) @(negedge clock);
        ifa.ack   = 1'b1;
        ifa.eol   = e;
        ifa.value = v;
        @(negedge clock);
        ifa.ack   = 1'b0;
        ifa.eol   = 1'b0;
        ifa.value = 8'd0;
    endtask

    task automatic finish_call();
        ready = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        ready     = 1'b0;
        ifa.ack   = 1'b0;
        ifa.eol   = 1'b0;
        ifa.value = 8'd0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_req",    {31'd0, ifa.req}, 32'd0);
        check("rst_done",   {31'd0, done_a},  32'd0);
        check("rst_result", {16'd0, result_a}, 32'd0);
        check("rst_count",  {24'd0, count_a}, 32'd0);
        check("rst_ovf",    {31'd0, ovf_a},   32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // List 1,2,3,eol with ack two cycles after each req rise
        ready = 1'b1;
        check("start_lat_req0", {31'd0, ifa.req}, 32'd0);
        @(negedge clock);
        check("start_lat_req1", {31'd0, ifa.req}, 32'd1);
        send(1'b0, 8'd1, 1);
        check("gap_req_low", {31'd0, ifa.req}, 32'd0);
        @(negedge clock);
        check("gap_req_high", {31'd0, ifa.req}, 32'd1);
        send(1'b0, 8'd2, 1);
        check("gap2_req_low", {31'd0, ifa.req}, 32'd0);
        send(1'b0, 8'd3, 1);
        send(1'b1, 8'd0, 1);
        check("l1_done",   {31'd0, done_a},  32'd1);
        check("l1_req",    {31'd0, ifa.req}, 32'd0);
        check("l1_result", {16'd0, result_a}, 32'd6);
        check("l1_count",  {24'd0, count_a}, 32'd3);
        check("l1_ovf",    {31'd0, ovf_a},   32'd0);
        @(negedge clock);
        check("l1_done_held", {31'd0, done_a}, 32'd1);
        finish_call();
        check("l1_done_fall", {31'd0, done_a}, 32'd0);

        // Empty list
        ready = 1'b1;
        @(negedge clock);
        send(1'b1, 8'hAA, 1);
        check("empty_done",   {31'd0, done_a},  32'd1);
        check("empty_result", {16'd0, result_a}, 32'd0);
        check("empty_count",  {24'd0, count_a}, 32'd0);
        finish_call();
        check("empty_done_fall", {31'd0, done_a}, 32'd0);
        check("empty_idle_req",  {31'd0, ifa.req}, 32'd0);

        // 200 + 100: 300 at 16 bits, wraps to 44 with carry at 8 bits
        ready = 1'b1;
        @(negedge clock);
        send(1'b0, 8'd200, 1);
        send(1'b0, 8'd100, 1);
        send(1'b1, 8'd0, 1);
        check("wrap16_result", {16'd0, result_a}, 32'd300);
        check("wrap16_ovf",    {31'd0, ovf_a},    32'd0);
        check("wrap8_done",    {31'd0, done_b},   32'd1);
        check("wrap8_result",  {24'd0, result_b}, 32'd44);
        check("wrap8_count",   {24'd0, count_b},  32'd2);
        check("wrap8_ovf",     {31'd0, ovf_b},    32'd1);
        finish_call();
        check("wrap8_ovf_held", {31'd0, ovf_b},   32'd1);
        ready = 1'b1;
        @(negedge clock);
        send(1'b0, 8'd1, 1);
        send(1'b1, 8'd0, 1);
        check("call2_ovf",    {31'd0, ovf_b},    32'd0);
        check("call2_result", {24'd0, result_b}, 32'd1);
        finish_call();

        // Spurious ack in IDLE
        ifa.ack = 1'b1; ifa.value = 8'hFF;
        @(negedge clock);
        ifa.ack = 1'b0; ifa.value = 8'd0;
        check("spur_idle_result", {16'd0, result_a}, 32'd1);
        check("spur_idle_count",  {24'd0, count_a},  32'd1);
        check("spur_idle_req",    {31'd0, ifa.req},  32'd0);
        // Spurious ack in GAP, then list 5, eol
        ready = 1'b1;
        @(negedge clock);
        send(1'b0, 8'd5, 1);
        ifa.ack = 1'b1; ifa.value = 8'hFF;
        @(negedge clock);
        ifa.ack = 1'b0; ifa.value = 8'd0;
        check("spur_gap_result", {16'd0, result_a}, 32'd5);
        check("spur_gap_count",  {24'd0, count_a},  32'd1);
        check("spur_gap_req",    {31'd0, ifa.req},  32'd1);
        send(1'b1, 8'd0, 1);
        check("spur_done",   {31'd0, done_a},   32'd1);
        check("spur_result", {16'd0, result_a}, 32'd5);
        finish_call();

        // Abort: ready drops with a same-cycle ack of 7
        ready = 1'b1;
        @(negedge clock);
        send(1'b0, 8'd3, 1);
        @(negedge clock);
        ready = 1'b0;
        ifa.ack = 1'b1; ifa.value = 8'd7;
        @(negedge clock);
        ifa.ack = 1'b0; ifa.value = 8'd0;
        check("abort_req",    {31'd0, ifa.req},  32'd0);
        check("abort_result", {16'd0, result_a}, 32'd3);
        check("abort_count",  {24'd0, count_a},  32'd1);
        check("abort_done",   {31'd0, done_a},   32'd0);
        repeat (3) @(negedge clock);
        check("abort_done_later", {31'd0, done_a}, 32'd0);

        // Asynchronous reset mid-call
        ready = 1'b1;
        @(negedge clock);
        send(1'b0, 8'd9, 1);
        @(negedge clock);
        check("pre_rst_result", {16'd0, result_a}, 32'd9);
        check("pre_rst_req",    {31'd0, ifa.req},  32'd1);
        #2 reset_n = 1'b0;
        ready = 1'b0;
        #1;
        check("arst_req",    {31'd0, ifa.req},  32'd0);
        check("arst_result", {16'd0, result_a}, 32'd0);
        check("arst_count",  {24'd0, count_a},  32'd0);
        check("arst_done",   {31'd0, done_a},   32'd0);
        check("arst_ovf",    {31'd0, ovf_a},    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

`ifdef LIST_SUM_TIMEOUT_EN
        // Ack 4, then silence for TIMEOUT=16 REQ cycles
        ready = 1'b1;
        @(negedge clock);
        send(1'b0, 8'd4, 1);
        repeat (16) @(negedge clock);
        check("tmo_req_last", {31'd0, ifa.req}, 32'd1);
        @(negedge clock);
        check("tmo_done",   {31'd0, done_a},   32'd1);
        check("tmo_err",    {31'd0, terr_a},   32'd1);
        check("tmo_result", {16'd0, result_a}, 32'd4);
        check("tmo_count",  {24'd0, count_a},  32'd1);
        finish_call();
        ready = 1'b1;
        @(negedge clock);
        check("tmo_err_clr", {31'd0, terr_a}, 32'd0);
        finish_call();
`else
        // No watchdog: req stays high without acks
        ready = 1'b1;
        @(negedge clock);
        repeat (99) @(negedge clock);
        check("nowd_req_100",  {31'd0, ifa.req}, 32'd1);
        check("nowd_done_100", {31'd0, done_a},  32'd0);
        finish_call();
        check("nowd_req_drop", {31'd0, ifa.req}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
